// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   IF_IW / IF_AW : instruction and address widths
//   IF_HALT_OP    : opcode that stops fetching when halt detection is built in
//   if_state_e    : fetch FSM state encoding
package instruction_fetch_pkg;

  localparam int unsigned IF_IW = 16;
  localparam int unsigned IF_AW = 16;
  localparam logic [IF_IW-1:0] IF_HALT_OP = 16'hFFFF;

  typedef enum logic {
    IF_RUN  = 1'b0,
    IF_HALT = 1'b1
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_fetch_queue.sv
// fetch_queue: two-entry in-order FIFO of {instruction, address}.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        empties the queue; wins over push/pop
//   push, push_instr, push_pc    enqueue at the tail (caller keeps count < 2 unless popping)
//   pop                          dequeue the head (caller keeps count > 0)
//   count                        occupancy 0..2
//   head_instr, head_pc          head entry, zero when empty
module fetch_queue
  import instruction_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [IF_IW-1:0] push_instr,
  input  logic [IF_AW-1:0] push_pc,
  output logic [1:0]       count,
  output logic [IF_IW-1:0] head_instr,
  output logic [IF_AW-1:0] head_pc
);

  // Slot 0 is always the head; popping shifts slot 1 down.
  logic [IF_IW-1:0] instr_q [2];
  logic [IF_AW-1:0] pc_q    [2];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            instr_q[0] <= push_instr;
            pc_q[0]    <= push_pc;
          end else begin
            instr_q[1] <= push_instr;
            pc_q[1]    <= push_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          instr_q[0] <= instr_q[1];
          pc_q[0]    <= pc_q[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: count holds, new word lands behind the survivor.
          if (count == 2'd1) begin
            instr_q[0] <= push_instr;
            pc_q[0]    <= push_pc;
          end else begin
            instr_q[0] <= instr_q[1];
            pc_q[0]    <= pc_q[1];
            instr_q[1] <= push_instr;
            pc_q[1]    <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_instr = (count == 2'd0) ? '0 : instr_q[0];
  assign head_pc    = (count == 2'd0) ? '0 : pc_q[0];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer feeding a two-entry queue toward decode.
// Parameter: RESET_PC - first fetch address after reset.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   A_InstrAddress, C_IMRead          instruction memory address / read strobe
//   D_Instruction                     combinational memory read data
//   C_Redirect, A_RedirectTarget      redirect request and target from execute
//   C_FetchValid, C_DecodeReady       head handshake toward decode
//   D_FetchedInstr, A_FetchedPC       queue head instruction and its address
//   C_Halted                          only with IF_HALT_DETECT_EN: fetch stopped on halt opcode
// Build option: define IF_HALT_DETECT_EN to stop fetching after queuing 16'hFFFF.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] A_InstrAddress,
  output logic        C_IMRead,
  input  logic [15:0] D_Instruction,
  input  logic        C_Redirect,
  input  logic [15:0] A_RedirectTarget,
  output logic        C_FetchValid,
  input  logic        C_DecodeReady,
  output logic [15:0] D_FetchedInstr,
  output logic [15:0] A_FetchedPC
`ifdef IF_HALT_DETECT_EN
  ,
  output logic        C_Halted
`endif
);

  logic [IF_AW-1:0] pc;
  if_state_e        state;
  logic [1:0]       count;
  logic [IF_IW-1:0] head_instr;
  logic [IF_AW-1:0] head_pc;
  logic             push;
  logic             pop;

  assign C_FetchValid   = ~rst & ~C_Redirect & (count != 2'd0);
  assign pop            = C_FetchValid & C_DecodeReady;
  assign push           = ~rst & (state == IF_RUN) & ~C_Redirect & ((count < 2'd2) | pop);
  assign C_IMRead       = push;
  assign A_InstrAddress = pc;

  // Queue state only clears on the reset edge, so mask the head while rst is high.
  assign D_FetchedInstr = rst ? '0 : head_instr;
  assign A_FetchedPC    = rst ? '0 : head_pc;

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (C_Redirect),
    .push       (push),
    .pop        (pop),
    .push_instr (D_Instruction),
    .push_pc    (pc),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= IF_RUN;
    end else if (C_Redirect) begin
      pc    <= A_RedirectTarget;
      state <= IF_RUN;
    end else if (push) begin
      pc <= pc + 16'd1;
`ifdef IF_HALT_DETECT_EN
      if (D_Instruction == IF_HALT_OP) state <= IF_HALT;
`endif
    end
  end

`ifdef IF_HALT_DETECT_EN
  assign C_Halted = (state == IF_HALT);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// random redirect/reset/backpressure, all compared cycle by cycle against a
// queue-based model of the fetch stage.
module tb_instruction_fetch;

  localparam logic [15:0] TB_RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A_InstrAddress;
  logic        C_IMRead;
  logic [15:0] D_Instruction;
  logic        C_Redirect = 1'b0;
  logic [15:0] A_RedirectTarget = '0;
  logic        C_FetchValid;
  logic        C_DecodeReady = 1'b0;
  logic [15:0] D_FetchedInstr;
  logic [15:0] A_FetchedPC;
`ifdef IF_HALT_DETECT_EN
  logic        C_Halted;
`endif

  logic [15:0] mem [0:65535];
  assign D_Instruction = mem[A_InstrAddress];

  instruction_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .A_InstrAddress   (A_InstrAddress),
    .C_IMRead         (C_IMRead),
    .D_Instruction    (D_Instruction),
    .C_Redirect       (C_Redirect),
    .A_RedirectTarget (A_RedirectTarget),
    .C_FetchValid     (C_FetchValid),
    .C_DecodeReady    (C_DecodeReady),
    .D_FetchedInstr   (D_FetchedInstr),
    .A_FetchedPC      (A_FetchedPC)
`ifdef IF_HALT_DETECT_EN
    ,
    .C_Halted         (C_Halted)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: in-order list of {instruction, address}, a PC and a halted flag.
  logic [31:0] mq[$];
  logic [15:0] mpc = '0;
  bit          mhalted = 1'b0;
  bit          pc_known = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs on the falling edge, check outputs, advance the model.
  task automatic step(input logic r, input logic red, input logic [15:0] tgt, input logic rdy);
    int          sz;
    bit          pop_e;
    bit          fetch_e;
    logic [15:0] w;
    @(negedge clk);
    rst = r; C_Redirect = red; A_RedirectTarget = tgt; C_DecodeReady = rdy;
    #1;
    sz      = mq.size();
    pop_e   = !r && !red && sz > 0 && rdy;
    fetch_e = !r && !mhalted && !red && (sz - int'(pop_e) < 2);
    check("imread", {15'd0, C_IMRead}, {15'd0, fetch_e});
    check("fetch_valid", {15'd0, C_FetchValid}, {15'd0, (!r && !red && sz > 0)});
    check("head_instr", D_FetchedInstr, (r || sz == 0) ? 16'h0000 : mq[0][31:16]);
    check("head_pc", A_FetchedPC, (r || sz == 0) ? 16'h0000 : mq[0][15:0]);
    if (pc_known) check("instr_addr", A_InstrAddress, mpc);
`ifdef IF_HALT_DETECT_EN
    if (pc_known) check("halted", {15'd0, C_Halted}, {15'd0, mhalted});
`endif
    if (r) begin
      mq.delete(); mpc = TB_RESET_PC; mhalted = 1'b0; pc_known = 1'b1;
    end else if (red) begin
      mq.delete(); mpc = tgt; mhalted = 1'b0;
    end else begin
      if (pop_e) void'(mq.pop_front());
      if (fetch_e) begin
        w = mem[mpc];
        mq.push_back({w, mpc});
        mpc = mpc + 16'd1;
`ifdef IF_HALT_DETECT_EN
        if (w == 16'hFFFF) mhalted = 1'b1;
`endif
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, rdy);
  endtask

  initial begin
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    // Streaming after reset at one instruction per cycle.
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    idle(6, 1'b1);

    // Backpressure: two pushes then stall, drain in order on release.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Redirect with a full queue.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    idle(3, 1'b1);

    // PC wrap-around.
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    idle(3, 1'b1);

    // Reset while full at PC 0x0040.
    step(1'b0, 1'b1, 16'h003E, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    idle(3, 1'b1);

`ifdef IF_HALT_DETECT_EN
    // Halt word at address 2, then resume by redirect.
    mem[2] = 16'hFFFF;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    idle(6, 1'b1);
    step(1'b0, 1'b1, 16'h0010, 1'b1);
    idle(3, 1'b1);
    mem[2] = 16'h3333;
`endif

    // Random traffic with occasional halt words.
    for (int unsigned i = 0; i < 16; i++) mem[$urandom_range(0, 255)] = 16'hFFFF;
    for (int unsigned i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 15) == 0),
           16'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port A_InstrAddress, output, 16: word address to instruction memory.
REQ-005 SHALL have port C_IMRead, output, 1: read strobe to instruction memory.
REQ-006 SHALL have port D_Instruction, input, 16: combinational read data, valid in the same cycle as C_IMRead.
REQ-007 SHALL have port C_Redirect, input, 1: branch/jump redirect request from execute.
REQ-008 SHALL have port A_RedirectTarget, input, 16: redirect word address.
REQ-009 SHALL have port C_FetchValid, output, 1: queue head valid toward decode.
REQ-010 SHALL have port C_DecodeReady, input, 1: decode accepts head this cycle.
REQ-011 SHALL have port D_FetchedInstr, output, 16: queue head instruction.
REQ-012 SHALL have port A_FetchedPC, output, 16: address of queue head instruction.

Function
REQ-013 SHALL hold a 16-bit PC register and a 2-entry FIFO of {instruction, address}, with a 2-bit occupancy count of 0..2.
REQ-014 SHALL drive A_InstrAddress = PC every cycle.
REQ-015 SHALL drive C_IMRead = 1 when not in reset, not halted, C_Redirect = 0, and (count < 2 or a pop occurs this cycle).
REQ-016 SHALL push {D_Instruction, PC} into the FIFO on each edge where C_IMRead = 1, and increment PC by 1 modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-017 SHALL pop when C_FetchValid & C_DecodeReady; C_FetchValid = (count != 0) & ~C_Redirect.
REQ-018 SHALL support a simultaneous push and pop at count = 2 and count = 1, leaving count unchanged and preserving order.
REQ-019 SHALL, on C_Redirect = 1, flush the FIFO (count <= 0), set PC <= A_RedirectTarget, and perform no push or pop that cycle; redirect has priority over all other events.
REQ-020 SHALL, when count = 0, drive D_FetchedInstr = 16'h0000 and A_FetchedPC = 16'h0000.
REQ-021 SHALL have a latency of 1 cycle from fetch to C_FetchValid; sustain throughput of 1 instruction/cycle while C_DecodeReady = 1.
REQ-022 SHALL hold FSM states RUN and HALT; after reset the state is RUN; HALT is exited only by C_Redirect (-> RUN) or rst.

Reset
REQ-023 SHALL, while rst = 1, set PC <= RESET_PC, count <= 0, state <= RUN, C_IMRead = 0, C_FetchValid = 0, and drive D_FetchedInstr and A_FetchedPC to 0.
REQ-024 SHALL, when rst is asserted mid-operation, discard queued entries; the first fetch at RESET_PC occurs in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with IF_HALT_DETECT_EN defined, enter HALT when a pushed instruction equals 16'hFFFF: the halt word is queued normally, fetching stops (C_IMRead = 0, PC frozen), and output C_Halted = 1 while in HALT.
REQ-026 SHALL, without IF_HALT_DETECT_EN, omit port C_Halted, treat 16'hFFFF as ordinary data, and never enter HALT.

Structure
REQ-027 SHALL take the shared package constants from the team's package: instruction width 16, address width 16, halt opcode 16'hFFFF, and the FSM state encoding typedef.
REQ-028 SHALL implement the 2-entry queue as sub-module fetch_queue (push, pop, flush, count, head data).

Verification
REQ-029 Reset then C_DecodeReady = 1 constantly, memory[0..3] = 16'h1111, 2222, 3333, 4444 -> one instruction/cycle with A_FetchedPC 0,1,2,3, first C_FetchValid one cycle after rst falls.
REQ-030 C_DecodeReady = 0 for 5 cycles -> C_IMRead drops after 2 pushes, PC = 2; on release, 16'h1111 at PC 0 emerges first with no loss or duplication.
REQ-031 C_Redirect = 1 with A_RedirectTarget = 16'h0100 while count = 2 -> C_FetchValid = 0 that cycle, next cycle A_InstrAddress = 16'h0100, old entries never delivered.
REQ-032 PC = 16'hFFFF -> next fetch address is 16'h0000.
REQ-033 rst pulsed while count = 2 and PC = 16'h0040 -> count = 0; after release A_InstrAddress = RESET_PC.
REQ-034 (IF_HALT_DETECT_EN) memory[2] = 16'hFFFF -> halt word delivered, C_Halted = 1, PC frozen at 3; C_Redirect to 16'h0010 resumes fetch.
